// File: rtl/mem_pkg.sv
// Shared constants and types for the MEM-stage data RAM responder and its
// posted write queue.
package mem_pkg;

  localparam int DEPTH      = 32;
  localparam int WQ_DEPTH   = 4;
  localparam int STARVE_MAX = 4;

  localparam int AW = $clog2(DEPTH);
  localparam int QW = $clog2(WQ_DEPTH);
  localparam int CW = $clog2(WQ_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [31:0]   data;
  } wq_entry_t;

  function automatic logic [AW-1:0] word_idx(input logic [31:0] adr);
    return adr[AW-1:0];
  endfunction

endpackage

// File: rtl/data_ram_resp_if.sv
// Store/load bus between the MEM stage and the data RAM responder, plus the
// read-only view of the committed array.
interface data_ram_resp_if;
  import mem_pkg::*;

  logic        wr_en;
  logic [31:0] wr_adr;
  logic [31:0] wr_data;
  logic        wr_stall;
  logic        wr_drop;
  logic        rd_en;
  logic [31:0] rd_adr;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        wq_empty;
  logic [31:0] ram_out [0:DEPTH-1];

  modport slave (
    input  wr_en, wr_adr, wr_data, rd_en, rd_adr,
    output wr_stall, wr_drop, rd_ready, rd_valid, rd_data, wq_empty, ram_out
  );

  modport master (
    output wr_en, wr_adr, wr_data, rd_en, rd_adr,
    input  wr_stall, wr_drop, rd_ready, rd_valid, rd_data, wq_empty, ram_out
  );

endinterface

// File: rtl/data_wq.sv
// Posted write queue: circular FIFO of pending stores with a combinational
// youngest-entry address match used for load forwarding.
module data_wq
  import mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  wq_entry_t     i_push_entry,
  input  logic          i_pop,
  input  logic [AW-1:0] i_search_adr,
  output wq_entry_t     o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_hit,
  output logic [31:0]   o_hit_data
);

  wq_entry_t     r_mem [WQ_DEPTH];
  logic [QW-1:0] r_head;
  logic [QW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [WQ_DEPTH-1:0] w_match;
  logic [QW-1:0]       w_slot [WQ_DEPTH];

  assign o_full  = (r_count == CW'(WQ_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_head];

  // Slot gi holds the gi-th oldest entry; only the first r_count are live.
  for (genvar gi = 0; gi < WQ_DEPTH; gi++) begin : g_age
    assign w_slot[gi]  = r_head + QW'(gi);
    assign w_match[gi] = (CW'(gi) < r_count) && (r_mem[w_slot[gi]].adr == i_search_adr);
  end

  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      if (w_match[i]) begin
        o_hit      = 1'b1;
        o_hit_data = r_mem[w_slot[i]].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_entry;
        r_tail        <= r_tail + 1'b1;
      end
      if (i_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/data_ram_resp.sv
// MEM-stage data RAM responder: posted stores drain into a single-port array,
// loads win arbitration until a starved queue forces a drain.
module data_ram_resp
  import mem_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  data_ram_resp_if.slave  bus
);

  logic [31:0]   r_ram [DEPTH];
  logic [31:0]   r_rd_data;
  logic          r_rd_valid;
  logic          r_wr_drop;
  logic [SW-1:0] r_starve;

  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_full;
  logic          w_empty;
  logic          w_hit;
  logic [31:0]   w_hit_data;
  wq_entry_t     w_head;
  wq_entry_t     w_push_entry;
  logic          w_wr_accept;
  logic          w_force;
  logic          w_rd_accept;
  logic          w_drain;
  logic [31:0]   w_rd_fwd;
  logic [SW-1:0] w_starve_next;
  logic          w_unused;

  assign w_wr_idx     = word_idx(bus.wr_adr);
  assign w_rd_idx     = word_idx(bus.rd_adr);
  assign w_unused     = ^{bus.wr_adr[31:AW], bus.rd_adr[31:AW]};
  assign w_push_entry = '{adr: w_wr_idx, data: bus.wr_data};

  // Full is judged on the registered count, so a drain in the same cycle
  // never makes room for a store.
  assign w_wr_accept = bus.wr_en && !w_full;
  assign w_force     = !w_empty && (r_starve == SW'(STARVE_MAX));
  assign w_rd_accept = bus.rd_en && !w_force;
  assign w_drain     = !w_empty && (w_force || !bus.rd_en);

  data_wq u_wq (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_wr_accept),
    .i_push_entry (w_push_entry),
    .i_pop        (w_drain),
    .i_search_adr (w_rd_idx),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_hit        (w_hit),
    .o_hit_data   (w_hit_data)
  );

  // Newest data wins: the store arriving this cycle, then the queue, then the array.
  always_comb begin
    w_rd_fwd = r_ram[w_rd_idx];
    if (w_wr_accept && (w_wr_idx == w_rd_idx)) begin
      w_rd_fwd = bus.wr_data;
    end else if (w_hit) begin
      w_rd_fwd = w_hit_data;
    end
  end

  always_comb begin
    w_starve_next = '0;
    if (!w_force && bus.rd_en && !w_empty) begin
      w_starve_next = (r_starve == SW'(STARVE_MAX)) ? r_starve : r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ram[i] <= '0;
      end
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_wr_drop  <= 1'b0;
      r_starve   <= '0;
    end else begin
      if (w_drain) begin
        r_ram[w_head.adr] <= w_head.data;
      end
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_rd_data <= w_rd_fwd;
      end
      r_wr_drop <= bus.wr_en && w_full;
      r_starve  <= w_starve_next;
    end
  end

  assign bus.wr_stall = w_full;
  assign bus.wq_empty = w_empty;
  assign bus.rd_ready = !w_force;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.wr_drop  = r_wr_drop;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ram_out
    assign bus.ram_out[gi] = r_ram[gi];
  end

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp: a per-cycle vector table plus hand-written
// reset sequences, with every expected value worked out by hand.
module tb_data_ram_resp;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  data_ram_resp_if bus();

  data_ram_resp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [31:0] wr_adr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_adr;
    logic        e_stall;
    logic        e_ready;
    logic        e_empty;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_drop;
    int          ram_idx;
    logic [31:0] ram_val;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [31:0] wa, logic [31:0] wd,
                              logic re, logic [31:0] ra,
                              logic st, logic rdy, logic emp,
                              logic vld, logic [31:0] dat, logic drp,
                              int ri, logic [31:0] rv);
    vec_t v;
    v.wr_en = we;  v.wr_adr = wa;  v.wr_data = wd;
    v.rd_en = re;  v.rd_adr = ra;
    v.e_stall = st; v.e_ready = rdy; v.e_empty = emp;
    v.e_valid = vld; v.e_data = dat; v.e_drop = drp;
    v.ram_idx = ri; v.ram_val = rv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic re, input logic [31:0] ra);
    bus.wr_en = we; bus.wr_adr = wa; bus.wr_data = wd;
    bus.rd_en = re; bus.rd_adr = ra;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst wq_empty", 32'(bus.wq_empty), 1);
    chk("rst wr_stall", 32'(bus.wr_stall), 0);
    chk("rst rd_ready", 32'(bus.rd_ready), 1);
    chk("rst rd_valid", 32'(bus.rd_valid), 0);
    chk("rst rd_data",  bus.rd_data, 0);
    chk("rst wr_drop",  32'(bus.wr_drop), 0);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("rst ram_out[%0d]", i), bus.ram_out[i], 0);
    $display("reset: wq_empty=%0d wr_stall=%0d rd_ready=%0d", bus.wq_empty, bus.wr_stall, bus.rd_ready);
    @(posedge clk); #1;

    //                 we wa  wd            re ra  st rdy emp vld data          drp ri  rv
    // Single store drains on the first idle cycle
    vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0,  0, 1, 1,  0, 0,            0,  5, 0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0, 1, 0,  0, 0,            0,  5, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0, 1, 1,  0, 0,            0,  5, 32'hDEADBEEF));
    // Continuous loads forward a pending store until starvation forces a drain
    vecs.push_back(mk(1, 7,  32'h11,       0, 0,  0, 1, 1,  0, 0,            0,  7, 0));
    vecs.push_back(mk(0, 0,  0,            1, 7,  0, 1, 0,  1, 32'h11,       0,  7, 0));
    vecs.push_back(mk(0, 0,  0,            1, 7,  0, 1, 0,  1, 32'h11,       0,  7, 0));
    vecs.push_back(mk(0, 0,  0,            1, 7,  0, 1, 0,  1, 32'h11,       0,  7, 0));
    vecs.push_back(mk(0, 0,  0,            1, 7,  0, 1, 0,  1, 32'h11,       0,  7, 0));
    vecs.push_back(mk(0, 0,  0,            1, 7,  0, 0, 0,  0, 0,            0,  7, 32'h11));
    vecs.push_back(mk(0, 0,  0,            1, 7,  0, 1, 1,  1, 32'h11,       0,  7, 32'h11));
    // Same-cycle store beats an older queued store to the same word
    vecs.push_back(mk(1, 3,  32'h55,       0, 0,  0, 1, 1,  0, 0,            0,  3, 0));
    vecs.push_back(mk(1, 3,  32'hAA,       1, 3,  0, 1, 0,  1, 32'hAA,       0,  3, 0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0, 1, 0,  0, 0,            0,  3, 32'h55));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0, 1, 0,  0, 0,            0,  3, 32'hAA));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0, 1, 1,  0, 0,            0,  3, 32'hAA));
    // Youngest queue entry wins among two pending stores to one word
    vecs.push_back(mk(1, 9,  32'h91,       1, 9,  0, 1, 1,  1, 32'h91,       0,  9, 0));
    vecs.push_back(mk(1, 9,  32'h92,       1, 9,  0, 1, 0,  1, 32'h92,       0,  9, 0));
    vecs.push_back(mk(0, 0,  0,            1, 9,  0, 1, 0,  1, 32'h92,       0,  9, 0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0, 1, 0,  0, 0,            0,  9, 32'h91));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0, 1, 0,  0, 0,            0,  9, 32'h92));
    // Address 37 aliases word 5
    vecs.push_back(mk(1, 37, 32'hCAFE0005, 0, 0,  0, 1, 1,  0, 0,            0,  5, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0, 1, 0,  0, 0,            0,  5, 32'hCAFE0005));
    vecs.push_back(mk(0, 0,  0,            1, 5,  0, 1, 1,  1, 32'hCAFE0005, 0,  5, 32'hCAFE0005));
    // Fill the queue under continuous loads; stores while full are dropped
    vecs.push_back(mk(1, 10, 32'hA0,       1, 20, 0, 1, 1,  1, 0,            0, 10, 0));
    vecs.push_back(mk(1, 11, 32'hA1,       1, 20, 0, 1, 0,  1, 0,            0, -1, 0));
    vecs.push_back(mk(1, 12, 32'hA2,       1, 20, 0, 1, 0,  1, 0,            0, -1, 0));
    vecs.push_back(mk(1, 13, 32'hA3,       1, 20, 0, 1, 0,  1, 0,            0, -1, 0));
    vecs.push_back(mk(1, 14, 32'hA4,       1, 20, 1, 1, 0,  1, 0,            1, -1, 0));
    vecs.push_back(mk(1, 15, 32'hA5,       1, 20, 1, 0, 0,  0, 0,            1, 10, 32'hA0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0, 1, 0,  0, 0,            0, 11, 32'hA1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0, 1, 0,  0, 0,            0, 12, 32'hA2));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0, 1, 0,  0, 0,            0, 13, 32'hA3));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0, 1, 1,  0, 0,            0, 14, 0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0, 1, 1,  0, 0,            0, 15, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr_en, vecs[i].wr_adr, vecs[i].wr_data, vecs[i].rd_en, vecs[i].rd_adr);
      @(negedge clk);
      chk($sformatf("v%0d wr_stall", i), 32'(bus.wr_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d rd_ready", i), 32'(bus.rd_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d wq_empty", i), 32'(bus.wq_empty), 32'(vecs[i].e_empty));
      @(posedge clk); #1;
      chk($sformatf("v%0d rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) chk($sformatf("v%0d rd_data", i), bus.rd_data, vecs[i].e_data);
      chk($sformatf("v%0d wr_drop", i), 32'(bus.wr_drop), 32'(vecs[i].e_drop));
      if (vecs[i].ram_idx >= 0)
        chk($sformatf("v%0d ram_out[%0d]", i, vecs[i].ram_idx), bus.ram_out[vecs[i].ram_idx], vecs[i].ram_val);
      $display("v%0d: wr_en=%0d wr_adr=%0d rd_en=%0d rd_adr=%0d -> rd_valid=%0d rd_data=0x%08h wr_drop=%0d",
               i, vecs[i].wr_en, vecs[i].wr_adr, vecs[i].rd_en, vecs[i].rd_adr,
               bus.rd_valid, bus.rd_data, bus.wr_drop);
    end

    // Reset with three stores pending (held back by continuous loads)
    for (int i = 1; i <= 3; i++) begin
      drive(1, 32'(i), 32'h100 + 32'(i), 1, 20);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 1, 20);
    @(negedge clk);
    chk("midq wq_empty before rst", 32'(bus.wq_empty), 0);
    chk("midq rd_ready before rst", 32'(bus.rd_ready), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    chk("midq wq_empty", 32'(bus.wq_empty), 1);
    chk("midq rd_valid", 32'(bus.rd_valid), 0);
    chk("midq rd_data",  bus.rd_data, 0);
    chk("midq ram_out[10] cleared", bus.ram_out[10], 0);
    $display("mid-queue reset: wq_empty=%0d rd_valid=%0d", bus.wq_empty, bus.rd_valid);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++) chk($sformatf("midq ram_out[%0d]", i), bus.ram_out[i], 0);
    chk("midq wq_empty idle", 32'(bus.wq_empty), 1);
    chk("midq rd_ready idle", 32'(bus.rd_ready), 1);
    $display("post-reset idle: ram_out[1..3]=0x%08h 0x%08h 0x%08h", bus.ram_out[1], bus.ram_out[2], bus.ram_out[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
